ppi_bus_master: RTL and testbench
=================================

Name: ppi_bus_master

Overview:
- Synchronous CPU-side sequencer that sits directly upstream of the 8255-style PPI and drives its chip pins: cs_n, rd_n, wr_n, the 2-bit port address and the bidirectional data bus.
- Converts a single-cycle valid/ready request (port read, port write, control-word write) into a timed setup/strobe/hold bus cycle, and returns read data through a one-cycle response pulse.
- Also generates the PPI reset pulse after system reset.

Parameters:
- SETUP_CYC, 2, cycles cs_n/addr/data are valid before the strobe falls (legal 1..255)
- STROBE_CYC, 4, cycles rd_n or wr_n stays low (legal 1..255)
- HOLD_CYC, 2, cycles cs_n/addr/data are held after the strobe rises (legal 1..255)
- RST_CYC, 4, cycles ppi_reset stays high after reset deasserts (legal 1..255)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_write  in  1  1=write, 0=read
- req_addr  in  2  0=port A, 1=port B, 2=port C, 3=control register
- req_wdata  in  8  write data or control word
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  8  read data, valid with rsp_valid
- rsp_err  out  1  illegal request flag, valid with rsp_valid
- busy  out  1  high in every state except IDLE
- ppi_reset  out  1  PPI reset, active-high
- ppi_cs_n  out  1  PPI chip select, active-low
- ppi_rd_n  out  1  PPI read strobe, active-low
- ppi_wr_n  out  1  PPI write strobe, active-low
- ppi_addr  out  2  PPI port address
- ppi_d  inout  8  PPI data bus; driven only during write cycles, otherwise high-Z

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset. All outputs are registered.
- Reset values: ppi_cs_n=1, ppi_rd_n=1, ppi_wr_n=1, ppi_addr=0, ppi_d=Z, ppi_reset=1, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=1. State = INIT with counter loaded to RST_CYC.
- INIT: ppi_reset=1 for RST_CYC cycles after reset falls, then ppi_reset=0 and the FSM goes to IDLE.
- IDLE: req_ready=1, busy=0.
  - A request is accepted on an edge where req_valid&req_ready; req_write, req_addr and req_wdata are latched at that edge.
  - Read with req_addr=3 (control read is unsupported): go to DONE, no strobe or cs_n activity, rsp_err=1, rsp_rdata=0.
  - Any other request: go to SETUP.
- SETUP (SETUP_CYC cycles): ppi_cs_n=0, ppi_addr=latched address. On a write, ppi_d is driven with the latched data.
- STROBE (STROBE_CYC cycles): ppi_rd_n=0 (read) or ppi_wr_n=0 (write); cs_n, addr and data unchanged. On a read, ppi_d is sampled into rsp_rdata at the edge ending the last STROBE cycle.
- HOLD (HOLD_CYC cycles): strobe back to 1; cs_n, addr and write data still held.
- DONE (1 cycle): ppi_cs_n=1, ppi_d=Z, rsp_valid=1, rsp_err=0 for normal requests; next state is IDLE.
- Latency: with accept at edge k, rsp_valid is high in cycle k+SETUP_CYC+STROBE_CYC+HOLD_CYC+1 (defaults: 9th cycle after accept). Back-to-back throughput is one request per S+T+H+2 cycles.
- Illegal control read: rsp_valid in the cycle after accept.
- Invariants:
  - rd_n and wr_n are never low simultaneously.
  - A strobe is never low while cs_n=1.
  - ppi_d is never driven during a read cycle, in INIT, or in IDLE.
- req_ready=0 outside IDLE. Requests presented while busy are ignored, not queued.
- Reset mid-cycle: on the next edge all strobes and cs_n go to 1, ppi_d is released, any pending response is discarded (no rsp_valid), and INIT restarts (PPI re-reset).
- Counter: one down-counter reloaded on each state entry; the state exits when the counter equals 1. Parameter value 1 gives exactly one cycle in that state.
- req_valid held high across DONE is accepted again in IDLE; one accept per IDLE cycle.

Decomposition:
- Shared package ppi_bus_pkg:
  - state enum INIT/IDLE/SETUP/STROBE/HOLD/DONE
  - address constants PPI_PORT_A=0, PPI_PORT_B=1, PPI_PORT_C=2, PPI_CTRL=3
  - control-word constants: CW_ALL_INPUT=8'h9B equivalent for the team's PPI encoding; BSR flag bit 7
  - default timing constants
- One sub-module: ppi_bus_timer, an 8-bit loadable down-counter with a done flag, shared by INIT and the bus phases.

Test Plan:
- Reset then release → ppi_reset high for exactly 4 cycles, then req_ready=1. During reset: cs_n=rd_n=wr_n=1 and ppi_d=Z.
- Write addr=3 data=8'h10 → cs_n low for 8 cycles, wr_n low for exactly 4 of them starting at cycle 3. ppi_d=8'h10 throughout cs_n low. rsp_valid in the 9th cycle with rsp_err=0.
- Read addr=0 with the external model driving 8'h81 → rd_n low 4 cycles, ppi_d never driven by the DUT, rsp_rdata=8'h81 with rsp_valid.
- Read addr=3 → no cs_n/strobe activity, rsp_valid in the next cycle with rsp_err=1 and rsp_rdata=0.
- Second req_valid asserted during a write → ignored until IDLE, then exactly one extra cycle executed. Check no overlap of wr_n/rd_n.
- Reset asserted during STROBE of a write → next edge wr_n=1, cs_n=1, ppi_d=Z, no rsp_valid, ppi_reset re-pulses for 4 cycles.

Source files
------------

// File: rtl/ppi_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ppi_bus_pkg
// Description : Shared types and constants for the 8255-style PPI bus master:
//               sequencer state encoding, PPI port addresses, control-word
//               constants, default bus timing and a request-decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ppi_bus_pkg;

  // Sequencer states. Explicit 3-bit encoding keeps the register width fixed.
  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_SETUP  = 3'd2,
    ST_STROBE = 3'd3,
    ST_HOLD   = 3'd4,
    ST_DONE   = 3'd5
  } ppi_state_t;

  // PPI port addresses (A1:A0).
  localparam logic [1:0] PPI_PORT_A = 2'd0;
  localparam logic [1:0] PPI_PORT_B = 2'd1;
  localparam logic [1:0] PPI_PORT_C = 2'd2;
  localparam logic [1:0] PPI_CTRL   = 2'd3;

  // Control word: mode 0, ports A, B and C all configured as inputs.
  localparam logic [7:0] CW_ALL_INPUT = 8'h9B;
  // Bit 7 of a control word: 1 = mode set, 0 = bit set/reset on port C.
  localparam int unsigned CW_BSR_FLAG_BIT = 7;

  // Default bus timing, in clock cycles.
  localparam int unsigned DEF_SETUP_CYC  = 2;
  localparam int unsigned DEF_STROBE_CYC = 4;
  localparam int unsigned DEF_HOLD_CYC   = 2;
  localparam int unsigned DEF_RST_CYC    = 4;

  // The PPI control register is write-only, so a read of it is rejected.
  function automatic logic f_is_ctrl_read(input logic i_write, input logic [1:0] i_addr);
    return (!i_write) && (i_addr == PPI_CTRL);
  endfunction

endpackage : ppi_bus_pkg
`default_nettype wire

// File: rtl/ppi_bus_timer.sv
`default_nettype none
// ============================================================================
// Module      : ppi_bus_timer
// Description : 8-bit loadable down-counter with a terminal flag. Shared by
//               the PPI reset phase and every bus phase of the sequencer.
//               The flag is high while the count equals 1, so a load value
//               of N marks the N-th cycle after the load as the last one.
// Ports       : clk        - clock
//               reset      - synchronous active-high reset, loads RESET_VAL
//               i_load     - reload the counter with i_load_val
//               i_load_val - value loaded on i_load
//               o_done     - current count equals 1
// Revision    : 1.0 - initial release
// ============================================================================
module ppi_bus_timer #(
  parameter logic [7:0] RESET_VAL = 8'd4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  output logic       o_done
);

  logic [7:0] r_cnt;

  // Counting stops at zero so an idle timer never wraps back into a
  // spurious terminal count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= RESET_VAL;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != 8'd0) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  assign o_done = (r_cnt == 8'd1);

endmodule : ppi_bus_timer
`default_nettype wire

// File: rtl/ppi_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : ppi_bus_master
// Description : CPU-side sequencer driving the chip pins of an 8255-style
//               PPI. A valid/ready request is turned into a timed
//               setup / strobe / hold bus cycle; completion is reported by a
//               one-cycle response pulse carrying read data or an error flag.
//               After system reset the PPI reset pin is pulsed high.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               i_req_valid/o_req_ready - request handshake
//               i_req_write, i_req_addr, i_req_wdata - request contents
//               o_rsp_valid, o_rsp_rdata, o_rsp_err  - completion pulse
//               o_busy              - high in every state except IDLE
//               o_ppi_reset, o_ppi_cs_n, o_ppi_rd_n, o_ppi_wr_n,
//               o_ppi_addr, io_ppi_d - PPI chip pins
// Revision    : 1.0 - initial release
// ============================================================================
module ppi_bus_master
  import ppi_bus_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = DEF_SETUP_CYC,
  parameter int unsigned STROBE_CYC = DEF_STROBE_CYC,
  parameter int unsigned HOLD_CYC   = DEF_HOLD_CYC,
  parameter int unsigned RST_CYC    = DEF_RST_CYC
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic       i_req_write,
  input  logic [1:0] i_req_addr,
  input  logic [7:0] i_req_wdata,
  output logic       o_rsp_valid,
  output logic [7:0] o_rsp_rdata,
  output logic       o_rsp_err,
  output logic       o_busy,
  output logic       o_ppi_reset,
  output logic       o_ppi_cs_n,
  output logic       o_ppi_rd_n,
  output logic       o_ppi_wr_n,
  output logic [1:0] o_ppi_addr,
  inout  wire  [7:0] io_ppi_d
);

  localparam logic [7:0] c_SETUP  = 8'(SETUP_CYC);
  localparam logic [7:0] c_STROBE = 8'(STROBE_CYC);
  localparam logic [7:0] c_HOLD   = 8'(HOLD_CYC);
  localparam logic [7:0] c_RST    = 8'(RST_CYC);

  ppi_state_t r_state;
  logic       r_write;
  logic [7:0] r_dout;
  logic       r_drive;
  logic       r_cs_n;
  logic       r_rd_n;
  logic       r_wr_n;
  logic [1:0] r_ppi_addr;
  logic       r_ppi_reset;
  logic       r_req_ready;
  logic       r_rsp_valid;
  logic [7:0] r_rsp_rdata;
  logic       r_rsp_err;
  logic       r_busy;

  logic       w_accept;
  logic       w_illegal;
  logic       w_tmr_load;
  logic [7:0] w_tmr_val;
  logic       w_tmr_done;

  // Ready is only ever high in IDLE, so this is the acceptance edge.
  assign w_accept  = r_req_ready && i_req_valid;
  assign w_illegal = f_is_ctrl_read(i_req_write, i_req_addr);

  // The timer is reloaded on the edge that enters a timed phase. The INIT
  // count comes from the timer's own reset value.
  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = c_SETUP;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = w_illegal ? 8'd1 : c_SETUP;
        end
      end
      ST_SETUP: begin
        if (w_tmr_done) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = c_STROBE;
        end
      end
      ST_STROBE: begin
        if (w_tmr_done) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = c_HOLD;
        end
      end
      default: begin
        w_tmr_load = 1'b0;
        w_tmr_val  = c_SETUP;
      end
    endcase
  end

  ppi_bus_timer #(
    .RESET_VAL (c_RST)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_done     (w_tmr_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_INIT;
      r_write     <= 1'b0;
      r_dout      <= 8'h00;
      r_drive     <= 1'b0;
      r_cs_n      <= 1'b1;
      r_rd_n      <= 1'b1;
      r_wr_n      <= 1'b1;
      r_ppi_addr  <= 2'd0;
      r_ppi_reset <= 1'b1;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 8'h00;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b1;
    end else begin
      // Response is a single-cycle pulse; only a transition into DONE sets it.
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_INIT: begin
          if (w_tmr_done) begin
            r_ppi_reset <= 1'b0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end

        ST_IDLE: begin
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_write     <= i_req_write;
            r_dout      <= i_req_wdata;
            r_rsp_rdata <= 8'h00;
            if (w_illegal) begin
              // Rejected without touching the PPI pins.
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_rsp_err   <= 1'b0;
              r_cs_n      <= 1'b0;
              r_ppi_addr  <= i_req_addr;
              r_drive     <= i_req_write;
              r_state     <= ST_SETUP;
            end
          end
        end

        ST_SETUP: begin
          if (w_tmr_done) begin
            // Exactly one strobe falls, selected by the request direction.
            r_rd_n  <= r_write;
            r_wr_n  <= ~r_write;
            r_state <= ST_STROBE;
          end
        end

        ST_STROBE: begin
          if (w_tmr_done) begin
            r_rd_n <= 1'b1;
            r_wr_n <= 1'b1;
            // Read data is captured while rd_n is still low on this edge.
            if (!r_write) begin
              r_rsp_rdata <= io_ppi_d;
            end
            r_state <= ST_HOLD;
          end
        end

        ST_HOLD: begin
          if (w_tmr_done) begin
            r_cs_n      <= 1'b1;
            r_drive     <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end

        ST_DONE: begin
          r_req_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end

        default: begin
          // Unreachable encodings: release the bus and drain through DONE.
          r_cs_n  <= 1'b1;
          r_rd_n  <= 1'b1;
          r_wr_n  <= 1'b1;
          r_drive <= 1'b0;
          r_state <= ST_DONE;
        end
      endcase
    end
  end

  assign io_ppi_d    = r_drive ? r_dout : 8'hzz;
  assign o_req_ready = r_req_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;
  assign o_busy      = r_busy;
  assign o_ppi_reset = r_ppi_reset;
  assign o_ppi_cs_n  = r_cs_n;
  assign o_ppi_rd_n  = r_rd_n;
  assign o_ppi_wr_n  = r_wr_n;
  assign o_ppi_addr  = r_ppi_addr;

endmodule : ppi_bus_master
`default_nettype wire

// File: tb/tb_ppi_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_ppi_bus_master
// Description : Self-checking bench for ppi_bus_master. A small PPI model
//               answers read strobes; expected responses are queued when a
//               request is accepted and compared when rsp_valid appears,
//               alongside per-cycle pin checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ppi_bus_master;

  localparam int S = 2;
  localparam int T = 4;
  localparam int H = 2;
  localparam int R = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_write = 1'b0;
  logic [1:0] req_addr = 2'd0;
  logic [7:0] req_wdata = 8'h00;
  logic       req_ready;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       busy;
  logic       ppi_reset;
  logic       ppi_cs_n;
  logic       ppi_rd_n;
  logic       ppi_wr_n;
  logic [1:0] ppi_addr;
  wire  [7:0] ppi_d;

  always #5 clk = ~clk;

  ppi_bus_master #(
    .SETUP_CYC  (S),
    .STROBE_CYC (T),
    .HOLD_CYC   (H),
    .RST_CYC    (R)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_write (req_write),
    .i_req_addr  (req_addr),
    .i_req_wdata (req_wdata),
    .o_rsp_valid (rsp_valid),
    .o_rsp_rdata (rsp_rdata),
    .o_rsp_err   (rsp_err),
    .o_busy      (busy),
    .o_ppi_reset (ppi_reset),
    .o_ppi_cs_n  (ppi_cs_n),
    .o_ppi_rd_n  (ppi_rd_n),
    .o_ppi_wr_n  (ppi_wr_n),
    .o_ppi_addr  (ppi_addr),
    .io_ppi_d    (ppi_d)
  );

  // PPI model: port contents returned on a read strobe.
  function automatic logic [7:0] f_model(input logic [1:0] a);
    case (a)
      2'd0:    return 8'h81;
      2'd1:    return 8'h42;
      2'd2:    return 8'h3C;
      default: return 8'hEE;
    endcase
  endfunction

  // Outside write cycles the bench owns the bus: 00 when idle, port data on
  // a read strobe. Any DUT drive then shows up as a corrupted value.
  logic       tb_wr_active = 1'b0;
  wire  [7:0] w_tb_val = (!ppi_cs_n && !ppi_rd_n) ? f_model(ppi_addr) : 8'h00;
  assign ppi_d = tb_wr_active ? 8'hzz : w_tb_val;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    logic       w;
    logic [1:0] a;
    logic [7:0] d;
    logic       err;
    logic [7:0] rdata;
    int         due;
  } exp_t;

  exp_t q[$];
  int   ncyc     = 0;
  int   cs_cnt   = 0;
  int   stb_cnt  = 0;
  int   rst_cnt  = 0;
  logic rst_prev = 1'b1;
  int   n_pulses = 0;
  int   n_rsp    = 0;
  int   n_acc    = 0;

  // Monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    chk("rdwr_excl", {31'd0, (!ppi_rd_n && !ppi_wr_n)}, 32'd0);
    chk("strobe_cs", {31'd0, ((!ppi_rd_n || !ppi_wr_n) && ppi_cs_n)}, 32'd0);
    if (!tb_wr_active) chk("bus_val", {24'd0, ppi_d}, {24'd0, w_tb_val});
    if (reset) begin
      q.delete();
      cs_cnt = 0;
      stb_cnt = 0;
      rst_cnt = 0;
      rst_prev = 1'b1;
      tb_wr_active = 1'b0;
    end else begin
      if (ppi_reset) rst_cnt++;
      else if (rst_prev) begin
        chk("rst_pulse_len", rst_cnt, R);
        n_pulses++;
      end
      rst_prev = ppi_reset;

      if (!ppi_cs_n) cs_cnt++;
      if (!ppi_cs_n && q.size() > 0) begin
        chk("ppi_addr", {30'd0, ppi_addr}, {30'd0, q[0].a});
        if (q[0].w) chk("wdata_bus", {24'd0, ppi_d}, {24'd0, q[0].d});
      end
      if (!ppi_rd_n || !ppi_wr_n) begin
        stb_cnt++;
        if (q.size() == 0) chk("stb_orphan", q.size(), 1);
        else begin
          chk("stb_kind", {31'd0, (q[0].w ? ppi_rd_n : ppi_wr_n)}, 32'd1);
          if (stb_cnt == 1) chk("stb_start", cs_cnt, S + 1);
        end
      end

      if (rsp_valid) begin
        if (q.size() == 0) chk("rsp_orphan", q.size(), 1);
        else begin
          e = q.pop_front();
          chk("rsp_cycle", ncyc, e.due);
          chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
          if (!e.w) chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e.rdata});
          chk("cs_low_cycles", cs_cnt, e.err ? 0 : S + T + H);
          chk("stb_low_cycles", stb_cnt, e.err ? 0 : T);
          n_rsp++;
        end
        tb_wr_active = 1'b0;
        cs_cnt = 0;
        stb_cnt = 0;
      end else if (q.size() > 0 && ncyc > q[0].due) begin
        chk("rsp_timeout", ncyc, q[0].due);
        void'(q.pop_front());
        tb_wr_active = 1'b0;
        cs_cnt = 0;
        stb_cnt = 0;
      end

      // Valid and ready both high here: the next rising edge accepts.
      if (req_valid && req_ready) begin
        chk("accept_one_at_a_time", q.size(), 0);
        e.w     = req_write;
        e.a     = req_addr;
        e.d     = req_wdata;
        e.err   = (!req_write && req_addr == 2'd3);
        e.rdata = e.err ? 8'h00 : f_model(req_addr);
        e.due   = ncyc + (e.err ? 1 : S + T + H + 1);
        q.push_back(e);
        n_acc++;
        if (req_write) tb_wr_active = 1'b1;
      end
    end
  end

  task automatic wait_accept();
    logic ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1'b1;
    end
    chk("accept_timeout", {31'd0, ok}, 32'd1);
    @(posedge clk) #1;
    req_valid = 1'b0;
  endtask

  task automatic present(input logic w, input logic [1:0] a, input logic [7:0] d);
    @(posedge clk) #1;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
  endtask

  task automatic send(input logic w, input logic [1:0] a, input logic [7:0] d);
    present(w, a, d);
    wait_accept();
  endtask

  initial begin
    logic seen;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cs_n", {31'd0, ppi_cs_n}, 32'd1);
    chk("rst_rd_n", {31'd0, ppi_rd_n}, 32'd1);
    chk("rst_wr_n", {31'd0, ppi_wr_n}, 32'd1);
    chk("rst_addr", {30'd0, ppi_addr}, 32'd0);
    chk("rst_ppi_reset", {31'd0, ppi_reset}, 32'd1);
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rdata", {24'd0, rsp_rdata}, 32'd0);
    chk("rst_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    @(posedge clk) #1;
    reset = 1'b0;

    send(1'b1, 2'd3, 8'h10);   // control-word write
    send(1'b0, 2'd0, 8'h00);   // port A read
    send(1'b0, 2'd3, 8'h00);   // illegal control read

    // Second request held high while busy: ignored until IDLE, then one accept.
    send(1'b1, 2'd1, 8'h5A);
    present(1'b0, 2'd2, 8'h00);
    chk("busy_not_ready", {31'd0, req_ready}, 32'd0);
    wait_accept();

    send(1'b0, 2'd1, 8'h00);
    send(1'b1, 2'd2, 8'hC3);

    // Reset in the middle of a write strobe.
    send(1'b1, 2'd0, 8'hF0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (!ppi_wr_n) seen = 1'b1;
    end
    chk("midrst_strobe_seen", {31'd0, seen}, 32'd1);
    @(posedge clk) #1;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_wr_n", {31'd0, ppi_wr_n}, 32'd1);
    chk("midrst_cs_n", {31'd0, ppi_cs_n}, 32'd1);
    chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midrst_ppi_reset", {31'd0, ppi_reset}, 32'd1);
    @(posedge clk) #1;
    reset = 1'b0;

    send(1'b0, 2'd2, 8'h00);   // port C read after re-init

    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("rsp_count", n_rsp, 8);
    chk("accept_count", n_acc, 9);
    chk("rst_pulse_count", n_pulses, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule : tb_ppi_bus_master
`default_nettype wire
